// File: rtl/alu_param.sv
// Purpose: registered execute-stage ALU (logic/add/sub/shift/mul) with C/N/Z condition codes.
// Latency: single-cycle ops update on the accept edge; MUL completes WIDTH edges after accept.
// Backpressure: busy is high while MUL iterates; requests seen while busy are dropped, not queued.
//
// Ports: clk, reset (async active-low), alu_en/func/a/b request, alu_out/mul_hi result,
//        carry_flag/negative_flag/zero_flag condition codes, busy, valid (one-cycle update pulse).
module alu_param #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_en,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] mul_hi,
  output logic             carry_flag,
  output logic             negative_flag,
  output logic             zero_flag,
  output logic             busy,
  output logic             valid
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_NOT   = 4'b0111;
  localparam logic [3:0] OP_INC   = 4'b1000;
  localparam logic [3:0] OP_DEC   = 4'b1001;
  localparam logic [3:0] OP_SHL   = 4'b1010;
  localparam logic [3:0] OP_SHR   = 4'b1011;
  localparam logic [3:0] OP_MUL   = 4'b1100;
  localparam logic [3:0] OP_SETC  = 4'b1101;
  localparam logic [3:0] OP_CLRC  = 4'b1110;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  // {partial high half, remaining multiplier bits / growing low half}
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     step_sum;

  logic               accept;
  logic               is_mul;
  logic [WIDTH-1:0]   res;
  logic               c_new;
  logic               wr_res;
  logic               wr_c;
  logic [WIDTH:0]     wide;
  logic [SW-1:0]      amt;

  assign accept = alu_en && (state_q == S_IDLE);
  assign is_mul = (func == OP_MUL);
  assign busy   = (state_q == S_MUL);
  assign amt    = b[SW-1:0];

  // One shift-add step: add multiplicand into the high half when the current
  // multiplier LSB is set, then shift the whole product register right.
  assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {step_sum, prod_q[WIDTH-1:1]};

  // Single-cycle datapath; wide carries the extra carry/borrow/shift-out bit.
  always_comb begin
    res    = alu_out;
    c_new  = carry_flag;
    wr_res = 1'b0;
    wr_c   = 1'b0;
    wide   = '0;
    case (func)
      OP_LOAD, OP_STORE: begin res = a; wr_res = 1'b1; end
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        res = wide[WIDTH-1:0]; c_new = wide[WIDTH]; wr_res = 1'b1; wr_c = 1'b1;
      end
      OP_SUB: begin
        // Top bit of the extended difference is the borrow (a < b unsigned).
        wide = {1'b0, a} - {1'b0, b};
        res = wide[WIDTH-1:0]; c_new = wide[WIDTH]; wr_res = 1'b1; wr_c = 1'b1;
      end
      OP_AND: begin res = a & b; wr_res = 1'b1; end
      OP_OR:  begin res = a | b; wr_res = 1'b1; end
      OP_NOT: begin res = ~a;    wr_res = 1'b1; end
      OP_INC: begin
        wide = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        res = wide[WIDTH-1:0]; c_new = wide[WIDTH]; wr_res = 1'b1; wr_c = 1'b1;
      end
      OP_DEC: begin
        wide = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
        res = wide[WIDTH-1:0]; c_new = wide[WIDTH]; wr_res = 1'b1; wr_c = 1'b1;
      end
      OP_SHL: begin
        // Bit WIDTH of the extended left shift is the last bit pushed out.
        wide = {1'b0, a} << amt;
        res = wide[WIDTH-1:0];
        c_new = (amt != '0) ? wide[WIDTH] : carry_flag;
        wr_res = 1'b1; wr_c = 1'b1;
      end
      OP_SHR: begin
        // Bit 0 of the extended right shift is the last bit pushed out.
        wide = {a, 1'b0} >> amt;
        res = wide[WIDTH:1];
        c_new = (amt != '0) ? wide[0] : carry_flag;
        wr_res = 1'b1; wr_c = 1'b1;
      end
      OP_SETC: begin c_new = 1'b1; wr_c = 1'b1; end
      OP_CLRC: begin c_new = 1'b0; wr_c = 1'b1; end
      default: ;  // NOP, MUL (handled by FSM), reserved
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (cnt_q == CNT_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_out       <= '0;
      mul_hi        <= '0;
      carry_flag    <= 1'b0;
      negative_flag <= 1'b0;
      zero_flag     <= 1'b0;
      valid         <= 1'b0;
      cnt_q         <= '0;
      mcand_q       <= '0;
      prod_q        <= '0;
    end else begin
      valid <= 1'b0;
      if (state_q == S_IDLE) begin
        if (accept && is_mul) begin
          mcand_q <= a;
          prod_q  <= {{WIDTH{1'b0}}, b};
          cnt_q   <= '0;
        end else if (accept) begin
          if (wr_res) begin
            alu_out       <= res;
            negative_flag <= res[WIDTH-1];
            zero_flag     <= (res == '0);
          end
          if (wr_c) carry_flag <= c_new;
          valid <= wr_res | wr_c;
        end
      end else begin
        prod_q <= prod_step;
        cnt_q  <= cnt_q + SW'(1);
        if (cnt_q == CNT_LAST) begin
          // Architectural outputs change only on the final iteration.
          alu_out       <= prod_step[WIDTH-1:0];
          mul_hi        <= prod_step[2*WIDTH-1:WIDTH];
          carry_flag    <= |prod_step[2*WIDTH-1:WIDTH];
          negative_flag <= prod_step[WIDTH-1];
          zero_flag     <= (prod_step == '0);
          valid         <= 1'b1;
          cnt_q         <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_param.sv
module tb_alu_param;

  logic        clk;
  logic        reset;
  logic        alu_en;
  logic [3:0]  func;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] alu_out;
  logic [15:0] mul_hi;
  logic        carry_flag;
  logic        negative_flag;
  logic        zero_flag;
  logic        busy;
  logic        valid;

  int n_pass  = 0;
  int n_total = 0;

  alu_param #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .alu_en(alu_en), .func(func), .a(a), .b(b),
    .alu_out(alu_out), .mul_hi(mul_hi), .carry_flag(carry_flag),
    .negative_flag(negative_flag), .zero_flag(zero_flag), .busy(busy), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot layout: {alu_out, mul_hi, C, N, Z, busy, valid}
  function automatic logic [36:0] obs();
    return {alu_out, mul_hi, carry_flag, negative_flag, zero_flag, busy, valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] f, input logic [15:0] va, input logic [15:0] vb);
    alu_en = en; func = f; a = va; b = vb;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 4'h3, 16'hFFFF, 16'hFFFF);
    tick(); tick();
    n_total++;
    if (obs() !== {16'h0000, 16'h0000, 5'b00000})
      $display("FAIL reset_state: got %h want %h", obs(), {16'h0000, 16'h0000, 5'b00000});
    else n_pass++;
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add();
    drive(1'b1, 4'h3, 16'h9555, 16'hFFFF);
    tick();
    n_total++;
    if (obs() !== {16'h9554, 16'h0000, 5'b11001})
      $display("FAIL add: got %h want %h", obs(), {16'h9554, 16'h0000, 5'b11001});
    else n_pass++;
    drive(1'b0, 4'h3, 16'h1111, 16'h1111);
    tick();
    n_total++;
    if (obs() !== {16'h9554, 16'h0000, 5'b11000})
      $display("FAIL add_valid_drop: got %h want %h", obs(), {16'h9554, 16'h0000, 5'b11000});
    else n_pass++;
  endtask

  task automatic test_sub_not_nop();
    drive(1'b1, 4'h4, 16'h0003, 16'h0005);
    tick();
    n_total++;
    if (obs() !== {16'hFFFE, 16'h0000, 5'b11001})
      $display("FAIL sub_borrow: got %h want %h", obs(), {16'hFFFE, 16'h0000, 5'b11001});
    else n_pass++;
    drive(1'b1, 4'h7, 16'hFFFF, 16'h0000);
    tick();
    n_total++;
    if (obs() !== {16'h0000, 16'h0000, 5'b10101})
      $display("FAIL not_zero: got %h want %h", obs(), {16'h0000, 16'h0000, 5'b10101});
    else n_pass++;
    drive(1'b1, 4'h0, 16'h1234, 16'h5678);
    tick();
    n_total++;
    if (obs() !== {16'h0000, 16'h0000, 5'b10100})
      $display("FAIL nop_hold: got %h want %h", obs(), {16'h0000, 16'h0000, 5'b10100});
    else n_pass++;
  endtask

  task automatic test_shift();
    drive(1'b1, 4'hA, 16'h8001, 16'h0001);
    tick();
    n_total++;
    if (obs() !== {16'h0002, 16'h0000, 5'b10001})
      $display("FAIL shl_carry: got %h want %h", obs(), {16'h0002, 16'h0000, 5'b10001});
    else n_pass++;
    drive(1'b1, 4'hB, 16'h0001, 16'h0000);
    tick();
    n_total++;
    if (obs() !== {16'h0001, 16'h0000, 5'b10001})
      $display("FAIL shr_zero_amt: got %h want %h", obs(), {16'h0001, 16'h0000, 5'b10001});
    else n_pass++;
    drive(1'b1, 4'hE, 16'hFFFF, 16'hFFFF);
    tick();
    n_total++;
    if (obs() !== {16'h0001, 16'h0000, 5'b00001})
      $display("FAIL clrc: got %h want %h", obs(), {16'h0001, 16'h0000, 5'b00001});
    else n_pass++;
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  f;
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] res;
    logic [2:0]  cnz;
    logic        vld;
  } vec_t;

  task automatic test_misc_ops();
    vec_t v[12];
    v[0]  = '{1'b1, 4'h5, 16'hF0F0, 16'hFF00, 16'hF000, 3'b010, 1'b1}; // AND
    v[1]  = '{1'b1, 4'hD, 16'h0000, 16'h0000, 16'hF000, 3'b110, 1'b1}; // SETC
    v[2]  = '{1'b1, 4'h6, 16'h0F0F, 16'h00F0, 16'h0FFF, 3'b100, 1'b1}; // OR
    v[3]  = '{1'b1, 4'hE, 16'h0000, 16'h0000, 16'h0FFF, 3'b000, 1'b1}; // CLRC
    v[4]  = '{1'b1, 4'h8, 16'hFFFF, 16'h0000, 16'h0000, 3'b101, 1'b1}; // INC wrap
    v[5]  = '{1'b1, 4'h9, 16'h8000, 16'h0000, 16'h7FFF, 3'b000, 1'b1}; // DEC
    v[6]  = '{1'b1, 4'h9, 16'h0000, 16'h0000, 16'hFFFF, 3'b110, 1'b1}; // DEC borrow
    v[7]  = '{1'b1, 4'hF, 16'h1234, 16'h4321, 16'hFFFF, 3'b110, 1'b0}; // reserved
    v[8]  = '{1'b1, 4'hB, 16'h8000, 16'h000F, 16'h0001, 3'b000, 1'b1}; // SHR by 15
    v[9]  = '{1'b0, 4'h3, 16'h1111, 16'h2222, 16'h0001, 3'b000, 1'b0}; // no request
    v[10] = '{1'b1, 4'h2, 16'hA5A5, 16'h0000, 16'hA5A5, 3'b010, 1'b1}; // PASS store
    v[11] = '{1'b1, 4'h1, 16'h0001, 16'h0000, 16'h0001, 3'b000, 1'b1}; // PASS load
    for (int i = 0; i < 12; i++) begin
      drive(v[i].en, v[i].f, v[i].va, v[i].vb);
      tick();
      n_total++;
      if (obs() !== {v[i].res, 16'h0000, v[i].cnz, 1'b0, v[i].vld})
        $display("FAIL misc_op[%0d]: got %h want %h", i, obs(), {v[i].res, 16'h0000, v[i].cnz, 1'b0, v[i].vld});
      else n_pass++;
    end
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    tick();
  endtask

  task automatic test_mul();
    int bcnt;
    int guard;
    // 0x00FF * 0x0101 = 0x0000_FFFF
    drive(1'b1, 4'hC, 16'h00FF, 16'h0101);
    tick();
    drive(1'b0, 4'h3, 16'h1234, 16'h4321);
    n_total++;
    if (obs() !== {16'h0001, 16'h0000, 5'b00010})
      $display("FAIL mul_hold_during_busy: got %h want %h", obs(), {16'h0001, 16'h0000, 5'b00010});
    else n_pass++;
    bcnt = 0; guard = 0;
    while (busy === 1'b1 && guard < 40) begin bcnt++; tick(); guard++; end
    n_total++;
    if (bcnt !== 16 || guard >= 40)
      $display("FAIL mul_busy_cycles: got %0d want 16", bcnt);
    else n_pass++;
    n_total++;
    if (obs() !== {16'hFFFF, 16'h0000, 5'b01001})
      $display("FAIL mul_result: got %h want %h", obs(), {16'hFFFF, 16'h0000, 5'b01001});
    else n_pass++;
    tick();
    n_total++;
    if (valid !== 1'b0)
      $display("FAIL mul_valid_pulse: got %b want 0", valid);
    else n_pass++;
    // 0xFFFF * 0xFFFF = 0xFFFE_0001
    drive(1'b1, 4'hC, 16'hFFFF, 16'hFFFF);
    tick();
    drive(1'b0, 4'h0, 16'h0000, 16'h0000);
    guard = 0;
    while (busy === 1'b1 && guard < 40) begin tick(); guard++; end
    n_total++;
    if (obs() !== {16'h0001, 16'hFFFE, 5'b10001} || guard >= 40)
      $display("FAIL mul_max: got %h want %h", obs(), {16'h0001, 16'hFFFE, 5'b10001});
    else n_pass++;
    tick();
  endtask

  task automatic test_busy_hold();
    int guard;
    int vcnt;
    drive(1'b1, 4'hC, 16'h0003, 16'h0005);
    tick();
    // ADD held on the bus for the whole multiply
    drive(1'b1, 4'h3, 16'h0001, 16'h0002);
    tick();
    n_total++;
    if (obs() !== {16'h0001, 16'hFFFE, 5'b10010})
      $display("FAIL busy_ignore_add: got %h want %h", obs(), {16'h0001, 16'hFFFE, 5'b10010});
    else n_pass++;
    guard = 0; vcnt = 0;
    while (busy === 1'b1 && guard < 40) begin tick(); guard++; end
    n_total++;
    if (obs() !== {16'h000F, 16'h0000, 5'b00001} || guard >= 40)
      $display("FAIL busy_mul_result: got %h want %h", obs(), {16'h000F, 16'h0000, 5'b00001});
    else n_pass++;
    tick();
    if (valid === 1'b1) vcnt++;
    n_total++;
    if (obs() !== {16'h0003, 16'h0000, 5'b00001})
      $display("FAIL busy_add_after: got %h want %h", obs(), {16'h0003, 16'h0000, 5'b00001});
    else n_pass++;
    drive(1'b0, 4'h3, 16'h0001, 16'h0002);
    for (int i = 0; i < 3; i++) begin tick(); if (valid === 1'b1) vcnt++; end
    n_total++;
    if (vcnt !== 1 || alu_out !== 16'h0003)
      $display("FAIL busy_single_add: got %0d pulses out %h want 1 pulses out 0003", vcnt, alu_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    drive(1'b1, 4'hC, 16'hFFFF, 16'hFFFF);
    tick();
    drive(1'b0, 4'h0, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    #1;
    n_total++;
    if (obs() !== {16'h0000, 16'h0000, 5'b00000})
      $display("FAIL reset_mid_mul: got %h want %h", obs(), {16'h0000, 16'h0000, 5'b00000});
    else n_pass++;
    tick(); tick();
    reset = 1'b1;
    tick();
    n_total++;
    if (obs() !== {16'h0000, 16'h0000, 5'b00000})
      $display("FAIL reset_release_idle: got %h want %h", obs(), {16'h0000, 16'h0000, 5'b00000});
    else n_pass++;
    drive(1'b1, 4'h3, 16'h0001, 16'h0001);
    tick();
    n_total++;
    if (obs() !== {16'h0002, 16'h0000, 5'b00001})
      $display("FAIL reset_then_add: got %h want %h", obs(), {16'h0002, 16'h0000, 5'b00001});
    else n_pass++;
    drive(1'b0, 4'h0, 16'h0000, 16'h0000);
    for (int i = 0; i < 20; i++) tick();
    n_total++;
    if (obs() !== {16'h0002, 16'h0000, 5'b00000})
      $display("FAIL reset_no_late_mul: got %h want %h", obs(), {16'h0002, 16'h0000, 5'b00000});
    else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    #2;
    test_reset();
    test_add();
    test_sub_not_nop();
    test_shift();
    test_misc_ops();
    test_mul();
    test_busy_hold();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_param.md
# alu_param

Parametrised, registered execute-stage ALU for the five-stage pipeline, successor to the fixed 16-bit ALU. Widens the opcode set to logic, subtract, shift and a multi-cycle unsigned multiply, and holds C/N/Z in a condition-code register. Multiply runs as an iterative shift-add state machine and raises `busy` so the hazard unit stalls the decode/execute boundary.

## Interface
- `WIDTH`, 16, operand/result width in bits (≥4, power of two).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `alu_en`  in  1  request strobe; an op is accepted on a rising edge with `alu_en`=1 and `busy`=0.
- `func`  in  4  opcode.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B (shift amount in `b[$clog2(WIDTH)-1:0]`).
- `alu_out`  out  WIDTH  registered result (MUL: low half).
- `mul_hi`  out  WIDTH  registered high half of last MUL product.
- `carry_flag`, `negative_flag`, `zero_flag`  out  1 each  condition-code register.
- `busy`  out  1  high while MUL iterates.
- `valid`  out  1  one-cycle pulse when `alu_out` and the flags have just been updated.

## Operation
- Opcodes:
  - 0000 NOP
  - 0001 PASS A (load)
  - 0010 PASS A (store)
  - 0011 ADD a+b
  - 0100 SUB a−b
  - 0101 AND
  - 0110 OR
  - 0111 NOT a
  - 1000 INC a
  - 1001 DEC a
  - 1010 SHL a by b
  - 1011 SHR (logical) a by b
  - 1100 MUL (unsigned)
  - 1101 SETC
  - 1110 CLRC
  - 1111 reserved (treated as NOP).
- NOP, 1111, and `alu_en`=0: `alu_out`, `mul_hi` and the flags hold. `valid`=0.
- ADD/INC: C = carry out of bit WIDTH−1.
- SUB/DEC: C = borrow, i.e. 1 when the unsigned minuend is less than the subtrahend.
- SHL/SHR: C = last bit shifted out. A shift amount of 0 leaves C unchanged.
- PASS, AND, OR, NOT: C unchanged.
- SETC/CLRC: only C written. `alu_out`, N and Z hold. `valid` pulses.
- All ops except NOP, SETC and CLRC: N = `alu_out[WIDTH-1]`, Z = (`alu_out`==0).
- All arithmetic is modulo 2^WIDTH.
- MUL:
  - Product is the 2·WIDTH-bit value {`mul_hi`,`alu_out`}.
  - C = |`mul_hi` (overflow of the low half).
  - Z = whole product is zero.
  - N = `alu_out[WIDTH-1]`.
  - Non-MUL ops leave `mul_hi` unchanged.
- FSM states: IDLE and MUL.
  - IDLE → MUL on an accepted MUL.
  - MUL iterates one multiplier bit per cycle using an internal counter.
  - MUL → IDLE after WIDTH iterations.
- Requests with `alu_en`=1 while `busy`=1 are ignored, not queued. Upstream must hold the instruction until `busy` falls.

## Timing
- Reset (`reset`=0, asynchronous): `alu_out`=0, `mul_hi`=0, C=N=Z=0, `busy`=0, `valid`=0, FSM=IDLE, counter=0.
- Single-cycle ops: accepted at edge k. `alu_out`, the flags and `valid`=1 are visible after edge k; `valid` returns to 0 after edge k+1 unless another op is accepted.
- Back-to-back single-cycle ops: one accepted per cycle, `valid` held high continuously.
- MUL accepted at edge k:
  - `busy`=1 from edge k through edge k+WIDTH.
  - Result, flags and `valid`=1 appear at edge k+WIDTH; `busy` falls at that same edge.
  - A new op may be accepted at edge k+WIDTH+1.
- During MUL, `alu_out`, `mul_hi` and the flags hold their pre-MUL values until completion.
- Reset asserted mid-MUL aborts the operation immediately to reset values. No partial result is written.
- Operands are captured at accept. Changes to `a`/`b` while busy have no effect.

## Test plan
- ADD, WIDTH=16: a=0x9555, b=0xFFFF → `alu_out`=0x9554, C=1, N=1, Z=0, `valid` high for one cycle after the accept edge.
- SUB a=0x0003, b=0x0005 → 0xFFFE, C=1, N=1, Z=0. Then NOT a=0xFFFF → 0x0000, Z=1, N=0, C still 1. Then NOP → all outputs hold, `valid`=0.
- SHL a=0x8001, b=1 → 0x0002, C=1. Then SHR a=0x0001, b=0 → 0x0001, C unchanged (still 1). Then CLRC → C=0, `alu_out` holds 0x0001.
- MUL a=0x00FF, b=0x0101 → `busy` high for exactly 16 cycles, then `alu_out`=0xFFFF, `mul_hi`=0x0000, C=0, N=1, Z=0, one `valid` pulse. Then MUL 0xFFFF×0xFFFF → `alu_out`=0x0001, `mul_hi`=0xFFFE, C=1.
- ADD request held with `alu_en`=1 during MUL busy → ignored until `busy` falls, then accepted on the next edge. Exactly one ADD result, and the MUL result is not corrupted.
- Assert `reset`=0 five cycles into a MUL → all outputs 0 immediately, `busy`=0. After release, ADD 0x0001+0x0001 → 0x0002, correct flags.
